// File: rtl/vixen_l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the L1 I-cache and D-cache.
// One transaction in flight at a time, with a timeout watchdog and saturating grant counters.
module vixen_l1_l2_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_we_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              l2_req_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic              l2_we_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic [LINE_W-1:0] l2_rdata_i,
  input  logic              l2_ack_i,
  output logic              err_timeout_o,
  output logic [CNT_W-1:0]  perf_ic_grants_o,
  output logic [CNT_W-1:0]  perf_dc_grants_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_last_q, rr_last_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               l2_req_q, l2_req_d;
  logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;
  logic               l2_we_q, l2_we_d;
  logic [LINE_W-1:0]  l2_wdata_q, l2_wdata_d;
  logic               ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;
  logic [LINE_W-1:0]  ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   perf_ic_q, perf_ic_d, perf_dc_q, perf_dc_d;
  logic               ic_elig_s, dc_elig_s, grant_dc_s;

  // Next-state, arbitration and output-register update logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    tmo_d      = tmo_q;
    l2_req_d   = l2_req_q;
    l2_addr_d  = l2_addr_q;
    l2_we_d    = l2_we_q;
    l2_wdata_d = l2_wdata_q;
    ic_ack_d   = 1'b0;
    dc_ack_d   = 1'b0;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    err_d      = 1'b0;
    perf_ic_d  = perf_ic_q;
    perf_dc_d  = perf_dc_q;

    // The previous owner is masked during HOLD while it lowers its request.
    ic_elig_s  = ic_req_i && !((state_q == HOLD) && (owner_q == OWN_IC));
    dc_elig_s  = dc_req_i && !((state_q == HOLD) && (owner_q == OWN_DC));
    grant_dc_s = dc_elig_s && (!ic_elig_s || (rr_last_q == OWN_IC));

    case (state_q)
      IDLE, HOLD: begin
        if (ic_elig_s || dc_elig_s) begin
          state_d   = BUSY;
          owner_d   = grant_dc_s;
          rr_last_d = grant_dc_s;
          tmo_d     = '0;
          l2_req_d  = 1'b1;
          if (grant_dc_s) begin
            l2_addr_d  = dc_addr_i;
            l2_we_d    = dc_we_i;
            l2_wdata_d = dc_wdata_i;
            perf_dc_d  = (&perf_dc_q) ? perf_dc_q : perf_dc_q + CNT_W'(1);
          end else begin
            l2_addr_d  = ic_addr_i;
            l2_we_d    = 1'b0;
            l2_wdata_d = '0;
            perf_ic_d  = (&perf_ic_q) ? perf_ic_q : perf_ic_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (l2_ack_i) begin
          state_d  = RESP;
          l2_req_d = 1'b0;
          if (owner_q == OWN_DC) begin
            dc_rdata_d = l2_rdata_i;
            dc_ack_d   = 1'b1;
          end else begin
            ic_rdata_d = l2_rdata_i;
            ic_ack_d   = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = RESP;
          l2_req_d = 1'b0;
          err_d    = 1'b1;
          if (owner_q == OWN_DC) begin
            dc_rdata_d = '0;
            dc_ack_d   = 1'b1;
          end else begin
            ic_rdata_d = '0;
            ic_ack_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        state_d = HOLD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; the I-cache wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      rr_last_q  <= OWN_DC;
      tmo_q      <= '0;
      l2_req_q   <= 1'b0;
      l2_addr_q  <= '0;
      l2_we_q    <= 1'b0;
      l2_wdata_q <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      err_q      <= 1'b0;
      perf_ic_q  <= '0;
      perf_dc_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      tmo_q      <= tmo_d;
      l2_req_q   <= l2_req_d;
      l2_addr_q  <= l2_addr_d;
      l2_we_q    <= l2_we_d;
      l2_wdata_q <= l2_wdata_d;
      ic_ack_q   <= ic_ack_d;
      dc_ack_q   <= dc_ack_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      err_q      <= err_d;
      perf_ic_q  <= perf_ic_d;
      perf_dc_q  <= perf_dc_d;
    end
  end

  assign ic_ack_o         = ic_ack_q;
  assign ic_rdata_o       = ic_rdata_q;
  assign dc_ack_o         = dc_ack_q;
  assign dc_rdata_o       = dc_rdata_q;
  assign l2_req_o         = l2_req_q;
  assign l2_addr_o        = l2_addr_q;
  assign l2_we_o          = l2_we_q;
  assign l2_wdata_o       = l2_wdata_q;
  assign err_timeout_o    = err_q;
  assign perf_ic_grants_o = perf_ic_q;
  assign perf_dc_grants_o = perf_dc_q;

endmodule
